// File: rtl/watch_param_if.sv
// Keypad/set-request inputs and 7-segment scan outputs of the parametrised watch.
interface watch_param_if;
    logic [9:0] keypad;
    logic       set_req;
    logic [7:0] seg_data;
    logic [7:0] seg_com;
    logic       running;

    modport master (output keypad, set_req, input seg_data, seg_com, running);
    modport slave  (input keypad, set_req, output seg_data, seg_com, running);
endinterface

// File: rtl/watch_param.sv
// Parametrised HH:MM:SS watch with keypad entry and multiplexed 7-segment scan.
// Optional macro BLINK_EN blanks the cursor digit on alternate half-seconds during entry.
module watch_param #(
    parameter int unsigned CLK_HZ   = 1000,
    parameter int unsigned SCAN_DIV = 1,
    parameter bit          HOUR_24  = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    watch_param_if.slave bus
);
    localparam int unsigned   TW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned   SW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(CLK_HZ - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

    typedef enum logic {ST_SET, ST_RUN} state_t;

    state_t        r_state, w_state_nxt;
    logic [2:0]    r_idx;
    logic [3:0]    r_dig [6];
    logic [3:0]    w_nxt [6];
    logic [TW-1:0] r_tick;
    logic [SW-1:0] r_scan_div;
    logic [2:0]    r_slot;
    logic [9:0]    r_key_prev;
    logic [7:0]    r_seg_data, r_seg_com;
    logic [3:0]    w_digit, w_val;
    logic [7:0]    w_pat;
    logic [5:2]    w_c;
    logic          w_press, w_ok, w_accept, w_tick, w_dp, w_blank, w_running;

    // A press needs exactly one key now and an idle keypad on the previous cycle.
    always_comb begin
        w_digit = '0;
        for (int unsigned k = 0; k < 10; k++)
            if (bus.keypad[k]) w_digit = 4'(k);
    end
    assign w_press = (bus.keypad != '0) && ((bus.keypad & (bus.keypad - 10'd1)) == '0)
                     && (r_key_prev == '0);

    always_comb begin
        w_ok = 1'b0;
        case (r_idx)
            3'd0: w_ok = HOUR_24 ? (w_digit <= 4'd2) : (w_digit <= 4'd1);
            3'd1: if (HOUR_24) w_ok = (r_dig[0] == 4'd2) ? (w_digit <= 4'd3) : 1'b1;
                  else         w_ok = (r_dig[0] == 4'd1) ? (w_digit <= 4'd2) : (w_digit != 4'd0);
            3'd2, 3'd4: w_ok = (w_digit <= 4'd5);
            3'd3, 3'd5: w_ok = 1'b1;
            default: w_ok = 1'b0;
        endcase
    end

    assign w_accept = (r_state == ST_SET) && w_press && w_ok && !bus.set_req;
    assign w_tick   = (r_state == ST_RUN) && (r_tick == TICK_MAX);

    // Carry chain for one-second advance
    always_comb begin
        w_c[5] = (r_dig[5] == 4'd9);
        w_c[4] = w_c[5] && (r_dig[4] == 4'd5);
        w_c[3] = w_c[4] && (r_dig[3] == 4'd9);
        w_c[2] = w_c[3] && (r_dig[2] == 4'd5);
        w_nxt[5] = w_c[5] ? 4'd0 : r_dig[5] + 4'd1;
        w_nxt[4] = !w_c[5] ? r_dig[4] : (w_c[4] ? 4'd0 : r_dig[4] + 4'd1);
        w_nxt[3] = !w_c[4] ? r_dig[3] : (w_c[3] ? 4'd0 : r_dig[3] + 4'd1);
        w_nxt[2] = !w_c[3] ? r_dig[2] : (w_c[2] ? 4'd0 : r_dig[2] + 4'd1);
        w_nxt[1] = r_dig[1];
        w_nxt[0] = r_dig[0];
        if (w_c[2]) begin
            if (HOUR_24 && r_dig[0] == 4'd2 && r_dig[1] == 4'd3) begin
                w_nxt[0] = 4'd0; w_nxt[1] = 4'd0;
            end else if (!HOUR_24 && r_dig[0] == 4'd1 && r_dig[1] == 4'd2) begin
                w_nxt[0] = 4'd0; w_nxt[1] = 4'd1;
            end else if (r_dig[1] == 4'd9) begin
                w_nxt[0] = r_dig[0] + 4'd1; w_nxt[1] = 4'd0;
            end else begin
                w_nxt[1] = r_dig[1] + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_SET;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_SET:  if (w_accept && r_idx == 3'd5) w_state_nxt = ST_RUN;
            ST_RUN:  if (bus.set_req) w_state_nxt = ST_SET;
            default: w_state_nxt = ST_SET;
        endcase
    end

    always_comb begin
        w_running = (r_state == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= '0;
            r_tick     <= '0;
            r_key_prev <= '0;
            r_dig[0]   <= HOUR_24 ? 4'd0 : 4'd1;
            r_dig[1]   <= HOUR_24 ? 4'd0 : 4'd2;
            for (int unsigned i = 2; i < 6; i++) r_dig[i] <= '0;
        end else begin
            r_key_prev <= bus.keypad;
            if (r_state == ST_SET) begin
                r_tick <= '0;
                if (bus.set_req) begin
                    r_idx <= '0;
                end else if (w_accept) begin
                    r_dig[r_idx] <= w_digit;
                    r_idx        <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
                end
            end else if (bus.set_req) begin
                r_tick <= '0;
                r_idx  <= '0;
            end else begin
                r_tick <= w_tick ? '0 : r_tick + TW'(1);
                if (w_tick) r_dig <= w_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_div <= '0;
            r_slot     <= '0;
        end else if (r_scan_div == SCAN_MAX) begin
            r_scan_div <= '0;
            r_slot     <= r_slot + 3'd1;
        end else begin
            r_scan_div <= r_scan_div + SW'(1);
        end
    end

`ifdef BLINK_EN
    localparam logic [TW-1:0] BLINK_MAX = TW'((CLK_HZ / 2 > 0) ? CLK_HZ / 2 - 1 : 0);
    logic [TW-1:0] r_blink_cnt;
    logic          r_blink;

    always_ff @(posedge clk) begin
        if (rst || r_state != ST_SET || bus.set_req || w_accept) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (r_blink_cnt == BLINK_MAX) begin
            r_blink_cnt <= '0;
            r_blink     <= ~r_blink;
        end else begin
            r_blink_cnt <= r_blink_cnt + TW'(1);
        end
    end
    assign w_blank = (r_state == ST_SET) && r_blink && (r_slot == r_idx);
`else
    assign w_blank = 1'b0;
`endif

    always_comb begin
        case (r_slot)
            3'd0: w_val = r_dig[0];
            3'd1: w_val = r_dig[1];
            3'd2: w_val = r_dig[2];
            3'd3: w_val = r_dig[3];
            3'd4: w_val = r_dig[4];
            3'd5: w_val = r_dig[5];
            default: w_val = 4'hF;
        endcase
        case (w_val)
            4'd0: w_pat = 8'hFC;  4'd1: w_pat = 8'h60;
            4'd2: w_pat = 8'hDA;  4'd3: w_pat = 8'hF2;
            4'd4: w_pat = 8'h66;  4'd5: w_pat = 8'hB6;
            4'd6: w_pat = 8'hBE;  4'd7: w_pat = 8'hE0;
            4'd8: w_pat = 8'hFE;  4'd9: w_pat = 8'hF6;
            default: w_pat = 8'h00;
        endcase
        w_dp = (r_state == ST_RUN) ? (r_slot == 3'd1 || r_slot == 3'd3) : (r_slot == r_idx);
    end

    always_ff @(posedge clk) begin
        if (rst || r_slot >= 3'd6) begin
            r_seg_com  <= '1;
            r_seg_data <= '0;
        end else begin
            r_seg_com  <= ~(8'h80 >> r_slot);
            r_seg_data <= w_blank ? 8'h00 : {w_pat[7:1], w_dp};
        end
    end

    assign bus.seg_com  = r_seg_com;
    assign bus.seg_data = r_seg_data;
    assign bus.running  = w_running;
endmodule
